collision_probe_scheduler: RTL and testbench
============================================

Name: collision_probe_scheduler

Overview:
- Time-shares the single combinational wall-lookup (Map) instance between the VGA draw path and per-frame character collision probing.
- Once per frame, at vertical-blank start, snapshots both character positions.
- Steps the Map inputs through 4 probe points per character, 8 probes total, and publishes per-character wall-contact flags to the movement logic.
- Top level muxes the Map inputs to probe_x/probe_y while probe_active=1, and to DrawX/DrawY otherwise.

Parameters:
- CHAR_W, 20, character sprite width in pixels.
- CHAR_H, 30, character sprite height in pixels.
- MAP_LAT, 0, extra wait cycles before sampling map_hit (0..3; nonzero for a registered/ROM map variant).
- SCR_W, 640, visible width.
- SCR_H, 480, visible height.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at vertical-blank start, already synchronous to Clk.
- blank  in  1  high during vertical blanking.
- p0_x, p0_y  in  10 each  character 0 (Fireboy) top-left.
- p1_x, p1_y  in  10 each  character 1 (Watergirl) top-left.
- map_hit  in  1  is_Wall from the shared Map.
- probe_x, probe_y  out  10 each  registered Map query coordinates.
- probe_active  out  1  Map inputs owned by the scheduler.
- p0_flags, p1_flags  out  4 each  bit order {right, left, top, bottom}; 1 = wall contact.
- done  out  1  one-cycle pulse when new flags are published.
- busy  out  1  sequence in progress.
- overrun  out  1  one-cycle pulse on an aborted or ignored sequence.

Behaviour:
- Reset (async, Reset=0): every output is 0, state IDLE, probe index 0.
- FSM states: IDLE, ISSUE, WAIT, SAMPLE.
- IDLE:
  - frame_start=1 at edge E0 → snapshot all four position inputs, clear the shadow flags, busy<=1, go ISSUE.
- ISSUE:
  - Register probe_x/probe_y for probe index k; probe_active<=1.
  - Go WAIT if MAP_LAT>0, else SAMPLE.
- WAIT:
  - Count MAP_LAT cycles, then go SAMPLE.
- SAMPLE:
  - shadow flag[k] <= map_hit, or 1 if probe k is off-screen.
  - If k<7: k++, go ISSUE.
  - If k=7: copy shadow to p0_flags/p1_flags, done<=1, busy<=0, probe_active<=0, go IDLE.
- Probe order: k=0..3 for character 0 (bottom, top, left, right), k=4..7 for character 1 in the same order.
- Probe coordinates, computed in 11-bit signed, with (x,y) = snapshot position:
  - bottom = (x+CHAR_W/2, y+CHAR_H)
  - top = (x+CHAR_W/2, y-1)
  - left = (x-1, y+CHAR_H/2)
  - right = (x+CHAR_W, y+CHAR_H/2)
- Off-screen probe (coordinate <0, x>=SCR_W, or y>=SCR_H):
  - Still occupies its ISSUE/WAIT/SAMPLE slot, so timing is fixed.
  - probe_x/probe_y driven as the coordinate clamped to the screen.
  - Flag forced to 1, map_hit ignored.
- Latency: 2+MAP_LAT cycles per probe. done is high in the cycle after edge E(8*(2+MAP_LAT)); with MAP_LAT=0 that is E16.
- frame_start while busy: ignored, overrun pulses, the current sequence continues.
- blank falls while busy:
  - Abort at the next edge: state IDLE, busy=0, probe_active=0, overrun pulses, no done.
  - p0_flags/p1_flags keep their previous values.
- frame_start with blank=0: ignored, overrun pulses.
- Position inputs changing mid-sequence: no effect; the snapshot is used.
- Flags change only on done; they hold between frames.
- done and overrun are never high in the same cycle.

Test Plan:
All scenarios use bench map model is_Wall=(y>=455)||(x<25), MAP_LAT=0, CHAR 20x30, blank=1 unless stated.
- Reset → all outputs 0; assert Reset=0 mid-sequence → outputs 0 immediately, asynchronously.
- p0=(300,425), p1=(30,100); pulse frame_start at E0:
  - probe k=0 at (310,455) registered at E1.
  - done high in the cycle after E16.
  - p0_flags=4'b0001, p1_flags=4'b0000.
  - busy high from E0 to E16.
- p0=(25,200): left probe x=24 → p0_flags=4'b0100. p0=(300,0): top probe y=-1 off-screen → top flag 1, probe_y=0.
- Drop blank at E7 → overrun pulse at E8, no done, flags unchanged from the prior frame, probe_active=0.
- Second frame_start at E5 → overrun pulse; done still at E16 with the E0 snapshot results.
- MAP_LAT=2: map model delayed 2 cycles → done after E32, same flag values as the MAP_LAT=0 run.

Source files
------------

// File: rtl/collision_probe_scheduler.sv
// Time-shares the single combinational wall lookup between the VGA draw path and a
// once-per-frame sweep of 8 collision probes (4 per character), publishing contact flags.
module collision_probe_scheduler #(
  parameter int CHAR_W  = 20,
  parameter int CHAR_H  = 30,
  parameter int MAP_LAT = 0,
  parameter int SCR_W   = 640,
  parameter int SCR_H   = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       blank,
  input  logic [9:0] p0_x,
  input  logic [9:0] p0_y,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic       map_hit,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  output logic       probe_active,
  output logic [3:0] p0_flags,
  output logic [3:0] p1_flags,
  output logic       done,
  output logic       busy,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  // Handshake: frame_start is a single-cycle request accepted only in IDLE with
  // blank high; done is a single-cycle completion strobe, overrun a single-cycle
  // rejection/abort strobe, and the two are mutually exclusive.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_SAMPLE = 2'd3;

  localparam logic [11:0] HALF_W   = 12'(CHAR_W / 2);
  localparam logic [11:0] FULL_W   = 12'(CHAR_W);
  localparam logic [11:0] HALF_H   = 12'(CHAR_H / 2);
  localparam logic [11:0] FULL_H   = 12'(CHAR_H);
  localparam logic [11:0] SCR_W_12 = 12'(SCR_W);
  localparam logic [11:0] SCR_H_12 = 12'(SCR_H);
  localparam logic [9:0]  MAX_X    = 10'(SCR_W - 1);
  localparam logic [9:0]  MAX_Y    = 10'(SCR_H - 1);
  localparam logic [1:0]  LAT_LAST = 2'(MAP_LAT - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [9:0] s0x_q, s0x_d, s0y_q, s0y_d;
  logic [9:0] s1x_q, s1x_d, s1y_q, s1y_d;
  logic [7:0] shadow_q, shadow_d;
  logic       off_q, off_d;
  logic [9:0] probe_x_q, probe_x_d, probe_y_q, probe_y_d;
  logic       active_q, active_d;
  logic [3:0] p0f_q, p0f_d, p1f_q, p1f_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;

  // Probe geometry: 12-bit two's complement so that x-1 / y-1 going negative and
  // x+CHAR_W running past the screen edge are both representable without wrap.
  logic [11:0] base_x, base_y, cx, cy;
  logic        x_neg, y_neg, x_big, y_big, off_c;
  logic [9:0]  clamp_x, clamp_y;

  always_comb begin
    base_x = {2'b00, (k_q[2] ? s1x_q : s0x_q)};
    base_y = {2'b00, (k_q[2] ? s1y_q : s0y_q)};
    case (k_q[1:0])
      2'd0: begin
        cx = base_x + HALF_W;
        cy = base_y + FULL_H;
      end
      2'd1: begin
        cx = base_x + HALF_W;
        cy = base_y - 12'd1;
      end
      2'd2: begin
        cx = base_x - 12'd1;
        cy = base_y + HALF_H;
      end
      default: begin
        cx = base_x + FULL_W;
        cy = base_y + HALF_H;
      end
    endcase
  end

  always_comb begin
    x_neg = cx[11];
    y_neg = cy[11];
    x_big = !cx[11] && (cx >= SCR_W_12);
    y_big = !cy[11] && (cy >= SCR_H_12);
    off_c = x_neg || y_neg || x_big || y_big;
    if (x_neg) begin
      clamp_x = 10'd0;
    end else if (x_big) begin
      clamp_x = MAX_X;
    end else begin
      clamp_x = cx[9:0];
    end
    if (y_neg) begin
      clamp_y = 10'd0;
    end else if (y_big) begin
      clamp_y = MAX_Y;
    end else begin
      clamp_y = cy[9:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wcnt_d    = wcnt_q;
    s0x_d     = s0x_q;
    s0y_d     = s0y_q;
    s1x_d     = s1x_q;
    s1y_d     = s1y_q;
    shadow_d  = shadow_q;
    off_d     = off_q;
    probe_x_d = probe_x_q;
    probe_y_d = probe_y_q;
    active_d  = active_q;
    p0f_d     = p0f_q;
    p1f_d     = p1f_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovr_d     = 1'b0;

    if (state_q == S_IDLE) begin
      if (frame_start) begin
        if (blank) begin
          s0x_d    = p0_x;
          s0y_d    = p0_y;
          s1x_d    = p1_x;
          s1y_d    = p1_y;
          shadow_d = 8'd0;
          k_d      = 3'd0;
          busy_d   = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end else if (!blank) begin
      // Active video has resumed: give the Map back to the draw path immediately.
      state_d  = S_IDLE;
      k_d      = 3'd0;
      busy_d   = 1'b0;
      active_d = 1'b0;
      ovr_d    = 1'b1;
    end else begin
      if (frame_start) begin
        ovr_d = 1'b1;
      end
      case (state_q)
        S_ISSUE: begin
          probe_x_d = clamp_x;
          probe_y_d = clamp_y;
          off_d     = off_c;
          active_d  = 1'b1;
          wcnt_d    = 2'd0;
          state_d   = (MAP_LAT > 0) ? S_WAIT : S_SAMPLE;
        end
        S_WAIT: begin
          if (wcnt_q == LAT_LAST) begin
            state_d = S_SAMPLE;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
        default: begin
          shadow_d[k_q] = off_q | map_hit;
          if (k_q == 3'd7) begin
            p0f_d    = shadow_d[3:0];
            p1f_d    = shadow_d[7:4];
            done_d   = 1'b1;
            ovr_d    = 1'b0;
            busy_d   = 1'b0;
            active_d = 1'b0;
            k_d      = 3'd0;
            state_d  = S_IDLE;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = S_ISSUE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      k_q       <= 3'd0;
      wcnt_q    <= 2'd0;
      s0x_q     <= 10'd0;
      s0y_q     <= 10'd0;
      s1x_q     <= 10'd0;
      s1y_q     <= 10'd0;
      shadow_q  <= 8'd0;
      off_q     <= 1'b0;
      probe_x_q <= 10'd0;
      probe_y_q <= 10'd0;
      active_q  <= 1'b0;
      p0f_q     <= 4'd0;
      p1f_q     <= 4'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wcnt_q    <= wcnt_d;
      s0x_q     <= s0x_d;
      s0y_q     <= s0y_d;
      s1x_q     <= s1x_d;
      s1y_q     <= s1y_d;
      shadow_q  <= shadow_d;
      off_q     <= off_d;
      probe_x_q <= probe_x_d;
      probe_y_q <= probe_y_d;
      active_q  <= active_d;
      p0f_q     <= p0f_d;
      p1f_q     <= p1f_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign probe_x      = probe_x_q;
  assign probe_y      = probe_y_q;
  assign probe_active = active_q;
  assign p0_flags     = p0f_q;
  assign p1_flags     = p1f_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_collision_probe_scheduler.sv
// Bench for collision_probe_scheduler: one instance with a combinational map and one
// with MAP_LAT=2 fed by a two-stage delayed map, both driven by the same stimulus.
module tb_collision_probe_scheduler;

  localparam int CW = 20;
  localparam int CH = 30;
  localparam int SW = 640;
  localparam int SH = 480;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       blank = 1'b1;
  logic [9:0] p0_x = '0, p0_y = '0, p1_x = '0, p1_y = '0;

  logic [9:0] px0, py0, px2, py2;
  logic       act0, act2, done0, done2, busy0, busy2, ovr0, ovr2;
  logic [3:0] f00, f01, f20, f21;
  logic [1:0] st0, st2;
  logic       map_hit0, map_hit2;
  logic       hit2_s1 = 1'b0, hit2_s2 = 1'b0;

  int total = 0;
  int bad = 0;
  logic [7:0] exp0_q[$];
  logic [7:0] exp2_q[$];

  typedef struct {
    int p0x, p0y, p1x, p1y;
    logic [3:0] e0, e1;
  } vec_t;
  vec_t vecs[5];

  collision_probe_scheduler #(.MAP_LAT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .blank(blank),
    .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y), .map_hit(map_hit0),
    .probe_x(px0), .probe_y(py0), .probe_active(act0),
    .p0_flags(f00), .p1_flags(f01), .done(done0), .busy(busy0),
    .overrun(ovr0), .dbg_state(st0)
  );

  collision_probe_scheduler #(.MAP_LAT(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .blank(blank),
    .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y), .map_hit(map_hit2),
    .probe_x(px2), .probe_y(py2), .probe_active(act2),
    .p0_flags(f20), .p1_flags(f21), .done(done2), .busy(busy2),
    .overrun(ovr2), .dbg_state(st2)
  );

  // ---------------- clock / map models ----------------
  always #5 Clk = ~Clk;

  function automatic bit is_wall(input int x, input int y);
    return (y >= 455) || (x < 25);
  endfunction

  assign map_hit0 = is_wall(int'(px0), int'(py0));

  always @(posedge Clk) begin
    hit2_s1 <= is_wall(int'(px2), int'(py2));
    hit2_s2 <= hit2_s1;
  end
  assign map_hit2 = hit2_s2;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // side: 0 bottom, 1 top, 2 left, 3 right
  function automatic int raw_px(input int x, input int side);
    if (side <= 1) return x + CW / 2;
    if (side == 2) return x - 1;
    return x + CW;
  endfunction

  function automatic int raw_py(input int y, input int side);
    if (side == 0) return y + CH;
    if (side == 1) return y - 1;
    return y + CH / 2;
  endfunction

  function automatic int clampv(input int v, input int lim);
    if (v < 0) return 0;
    if (v >= lim) return lim - 1;
    return v;
  endfunction

  function automatic logic [3:0] ref_flags(input int x, input int y);
    logic [3:0] f;
    f = '0;
    for (int s = 0; s < 4; s++) begin
      int qx, qy;
      qx = raw_px(x, s);
      qy = raw_py(y, s);
      if (qx < 0 || qx >= SW || qy < 0 || qy >= SH) f[s] = 1'b1;
      else f[s] = is_wall(qx, qy);
    end
    return f;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_px0"}, int'(px0), 0);
    check({tag, "_py0"}, int'(py0), 0);
    check({tag, "_act0"}, int'(act0), 0);
    check({tag, "_flags0"}, int'({f01, f00}), 0);
    check({tag, "_done0"}, int'(done0), 0);
    check({tag, "_busy0"}, int'(busy0), 0);
    check({tag, "_ovr0"}, int'(ovr0), 0);
    check({tag, "_state0"}, int'(st0), 0);
    check({tag, "_px2"}, int'(px2), 0);
    check({tag, "_act2"}, int'(act2), 0);
    check({tag, "_flags2"}, int'({f21, f20}), 0);
    check({tag, "_busy2"}, int'(busy2), 0);
  endtask

  // ---------------- driver ----------------
  // drop_at / refire_at name the clock edge (counted from E0) that first sees
  // blank low / a second frame_start; -1 disables.
  task automatic run_frame(input int a0x, input int a0y, input int a1x, input int a1y,
                           input logic [3:0] e0, input logic [3:0] e1,
                           input int drop_at, input int refire_at);
    int d0_n, d2_n, d0_cnt, d2_cnt, o0_n, o2_n, o0_cnt;
    logic [7:0] prev0, prev2, e;
    prev0 = {f01, f00};
    prev2 = {f21, f20};
    if (drop_at < 0) begin
      exp0_q.push_back({e1, e0});
      exp2_q.push_back({e1, e0});
    end
    d0_n = -1; d2_n = -1; d0_cnt = 0; d2_cnt = 0; o0_n = -1; o2_n = -1; o0_cnt = 0;
    @(negedge Clk);
    p0_x = 10'(a0x); p0_y = 10'(a0y); p1_x = 10'(a1x); p1_y = 10'(a1y);
    frame_start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    frame_start = 1'b0;
    check("busy_after_e0_0", int'(busy0), 1);
    check("busy_after_e0_2", int'(busy2), 1);
    // the snapshot, not the live inputs, must drive the probes
    p0_x = 10'($urandom_range(639, 0)); p0_y = 10'($urandom_range(479, 0));
    p1_x = 10'($urandom_range(639, 0)); p1_y = 10'($urandom_range(479, 0));
    for (int n = 1; n <= 36; n++) begin
      if (n == refire_at) frame_start = 1'b1;
      if (n == drop_at) blank = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      frame_start = 1'b0;
      check("done_ovr_excl0", int'(done0 & ovr0), 0);
      check("done_ovr_excl2", int'(done2 & ovr2), 0);
      if (ovr0) begin o0_cnt++; if (o0_n < 0) o0_n = n; end
      if (ovr2 && o2_n < 0) o2_n = n;
      if (drop_at < 0 || n < drop_at) begin
        if ((n % 2) == 1 && n <= 15) begin
          int k, x, y;
          k = (n - 1) / 2;
          x = (k < 4) ? a0x : a1x;
          y = (k < 4) ? a0y : a1y;
          check("probe_x_lat0", int'(px0), clampv(raw_px(x, k % 4), SW));
          check("probe_y_lat0", int'(py0), clampv(raw_py(y, k % 4), SH));
          check("probe_active_lat0", int'(act0), 1);
        end
        if ((n % 4) == 1 && n <= 29) begin
          int k, x, y;
          k = (n - 1) / 4;
          x = (k < 4) ? a0x : a1x;
          y = (k < 4) ? a0y : a1y;
          check("probe_x_lat2", int'(px2), clampv(raw_px(x, k % 4), SW));
          check("probe_y_lat2", int'(py2), clampv(raw_py(y, k % 4), SH));
        end
      end
      if (done0) begin
        d0_cnt++;
        if (d0_n < 0) d0_n = n;
        if (exp0_q.size() == 0) check("spurious_done0", 1, 0);
        else begin
          e = exp0_q.pop_front();
          check("flags_lat0", int'({f01, f00}), int'(e));
        end
      end
      if (done2) begin
        d2_cnt++;
        if (d2_n < 0) d2_n = n;
        if (exp2_q.size() == 0) check("spurious_done2", 1, 0);
        else begin
          e = exp2_q.pop_front();
          check("flags_lat2", int'({f21, f20}), int'(e));
        end
      end
      if (n == 16 && drop_at < 0) begin
        check("busy_clear_e16", int'(busy0), 0);
        check("active_clear_e16", int'(act0), 0);
      end
      if (n == 15 && drop_at < 0) check("busy_held_e15", int'(busy0), 1);
    end
    if (drop_at < 0) begin
      check("done_cycle_lat0", d0_n, 16);
      check("done_cycle_lat2", d2_n, 32);
      check("done_count_lat0", d0_cnt, 1);
      check("done_count_lat2", d2_cnt, 1);
    end else begin
      check("abort_no_done0", d0_cnt, 0);
      check("abort_no_done2", d2_cnt, 0);
      check("abort_flags_kept0", int'({f01, f00}), int'(prev0));
      check("abort_flags_kept2", int'({f21, f20}), int'(prev2));
      check("abort_active0", int'(act0), 0);
      check("abort_busy2", int'(busy2), 0);
      blank = 1'b1;
    end
    if (refire_at >= 0) begin
      check("refire_ovr_cycle0", o0_n, refire_at);
      check("refire_ovr_cycle2", o2_n, refire_at);
    end else if (drop_at >= 0) begin
      check("abort_ovr_cycle0", o0_n, drop_at);
      check("abort_ovr_cycle2", o2_n, drop_at);
    end else begin
      check("no_overrun0", o0_cnt, 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{p0x: 300, p0y: 425, p1x: 30,  p1y: 100, e0: 4'b0001, e1: 4'b0000};
    vecs[1] = '{p0x: 25,  p0y: 200, p1x: 300, p1y: 0,   e0: 4'b0100, e1: 4'b0010};
    vecs[2] = '{p0x: 0,   p0y: 0,   p1x: 620, p1y: 450, e0: 4'b1111, e1: 4'b1101};
    vecs[3] = '{p0x: 100, p0y: 100, p1x: 400, p1y: 300, e0: 4'b0000, e1: 4'b0000};
    vecs[4] = '{p0x: 30,  p0y: 430, p1x: 621, p1y: 300, e0: 4'b0001, e1: 4'b1000};

    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].p0x, vecs[i].p0y, vecs[i].p1x, vecs[i].p1y,
                vecs[i].e0, vecs[i].e1, -1, -1);
    end

    // frame_start during active video is refused
    @(negedge Clk);
    blank = 1'b0;
    frame_start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    frame_start = 1'b0;
    check("fs_no_blank_ovr0", int'(ovr0), 1);
    check("fs_no_blank_ovr2", int'(ovr2), 1);
    check("fs_no_blank_busy0", int'(busy0), 0);
    blank = 1'b1;
    @(negedge Clk);
    check("fs_no_blank_ovr_pulse0", int'(ovr0), 0);

    // blank drops mid-sweep: seen at E8
    run_frame(0, 0, 620, 450, 4'b0, 4'b0, 8, -1);
    // second frame_start seen at E5
    run_frame(300, 425, 30, 100, 4'b0001, 4'b0000, -1, 5);

    for (int i = 0; i < 8; i++) begin
      int a, b, c, d;
      a = int'($urandom_range(660, 0));
      b = int'($urandom_range(500, 0));
      c = int'($urandom_range(660, 0));
      d = int'($urandom_range(500, 0));
      run_frame(a, b, c, d, ref_flags(a, b), ref_flags(c, d), -1, -1);
    end

    // asynchronous reset in the middle of a sweep
    @(negedge Clk);
    p0_x = 10'd300; p0_y = 10'd425; p1_x = 10'd30; p1_y = 10'd100;
    frame_start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (5) @(negedge Clk);
    check("mid_seq_busy0", int'(busy0), 1);
    #1 Reset = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge Clk);
    Reset = 1'b1;

    run_frame(25, 200, 300, 0, 4'b0100, 4'b0010, -1, -1);

    check("exp0_q_drained", exp0_q.size(), 0);
    check("exp2_q_drained", exp2_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
